// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution engine.
// Kernel/state typedefs, accumulator sizing and saturation.
package conv_pkg;

   localparam int DEF_PIX_W  = 8;
   localparam int DEF_COEF_W = 8;
   localparam int DEF_OUT_W  = 16;

   typedef logic signed [DEF_COEF_W-1:0] coef_t;
   typedef coef_t [0:2][0:2] kernel_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // Adder-tree width: 9 exact products never overflow this.
   function automatic int acc_w(input int pix_w, input int coef_w);
      return pix_w + coef_w + 5;
   endfunction

   // Clamp a wide signed value into the range of an ow-bit signed word.
   function automatic logic signed [31:0] sat_narrow(
      input logic signed [31:0] v,
      input int                 ow
   );
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

endpackage

// File: rtl/conv_window_3x3.sv
// Line buffers, raster counters and 3x3 sliding window.
// Window element r*3+c holds p[y-2+r][x-2+c] for the last accepted pixel.
module conv_window_3x3
   import conv_pkg::*;
#(
   parameter int MAX_WIDTH  = 64,
   parameter int MAX_HEIGHT = 64,
   parameter int PIX_W      = DEF_PIX_W
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clr,
   input  logic                              en,
   input  logic                              accept,
   input  logic [PIX_W-1:0]                  pix,
   input  logic [$clog2(MAX_WIDTH+1)-1:0]    width,
   input  logic [$clog2(MAX_HEIGHT+1)-1:0]   height,
   output logic [8:0][PIX_W-1:0]             win,
   output logic                              win_valid,
   output logic                              last
);

   localparam int WW = $clog2(MAX_WIDTH + 1);
   localparam int HW = $clog2(MAX_HEIGHT + 1);
   localparam int AW = $clog2(MAX_WIDTH);

   logic [WW-1:0]    x;
   logic [HW-1:0]    y;
   logic [PIX_W-1:0] lb0 [MAX_WIDTH];
   logic [PIX_W-1:0] lb1 [MAX_WIDTH];
   logic [AW-1:0]    xi;
   logic             x_end;
   logic             y_end;
   logic             interior;

   assign xi       = x[AW-1:0];
   assign x_end    = (x == width - WW'(1));
   assign y_end    = (y == height - HW'(1));
   assign interior = (x >= WW'(2)) && (y >= HW'(2));
   assign last     = accept && x_end && y_end;

   // Raster position of the next pixel; restarts at each frame.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         x <= '0;
         y <= '0;
      end else if (accept) begin
         if (x_end) begin
            x <= '0;
            y <= y + HW'(1);
         end else begin
            x <= x + WW'(1);
         end
      end
   end

   // Line buffers: lb0 holds row y-1, lb1 holds row y-2 at column x.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[xi] <= lb0[xi];
         lb0[xi] <= pix;
      end
   end

   // Shift a new column into the window; flag interior positions.
   always_ff @(posedge clk) begin
      if (rst) begin
         win       <= '0;
         win_valid <= 1'b0;
      end else if (en) begin
         win_valid <= accept && interior;
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win[r*3+0] <= win[r*3+1];
               win[r*3+1] <= win[r*3+2];
            end
            win[2] <= lb1[xi];
            win[5] <= lb0[xi];
            win[8] <= pix;
         end
      end
   end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 valid-mode convolution with loadable kernel,
// optional ReLU and saturating output, full valid/ready flow control.
module conv2d_stream_engine
   import conv_pkg::*;
#(
   parameter int MAX_WIDTH  = 64,
   parameter int MAX_HEIGHT = 64,
   parameter int PIX_W      = DEF_PIX_W,
   parameter int COEF_W     = DEF_COEF_W,
   parameter int OUT_W      = DEF_OUT_W
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [$clog2(MAX_WIDTH+1)-1:0]    cfg_width,
   input  logic [$clog2(MAX_HEIGHT+1)-1:0]   cfg_height,
   input  logic                              relu_en,
   input  logic                              coef_we,
   input  logic [3:0]                        coef_addr,
   input  logic signed [COEF_W-1:0]          coef_data,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [PIX_W-1:0]                  s_data,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic signed [OUT_W-1:0]           m_data,
   output logic                              busy,
   output logic                              done
);

   localparam int WW    = $clog2(MAX_WIDTH + 1);
   localparam int HW    = $clog2(MAX_HEIGHT + 1);
   localparam int ACC_W = acc_w(PIX_W, COEF_W);
   localparam int PW    = PIX_W + 1 + COEF_W;

   state_t                    state;
   state_t                    state_nxt;
   logic [WW-1:0]             width_q;
   logic [HW-1:0]             height_q;
   logic                      relu_q;
   kernel_t                   kern;
   logic                      en;
   logic                      accept;
   logic                      clr;
   logic                      last;
   logic                      cfg_ok;
   logic [8:0][PIX_W-1:0]     win;
   logic                      win_valid;
   logic signed [PW-1:0]      prod [9];
   logic                      v2;
   logic signed [ACC_W-1:0]   sum_c;
   logic signed [ACC_W-1:0]   sum_q;
   logic                      v3;
   logic signed [ACC_W-1:0]   act_c;

   assign en      = !m_valid || m_ready;
   assign s_ready = (state == RUN) && en;
   assign accept  = s_valid && s_ready;
   assign clr     = (state == IDLE) && start;
   assign busy    = (state == RUN) || (state == DRAIN);
   assign done    = (state == DONE);
   assign cfg_ok  = (cfg_width >= WW'(3)) && (cfg_width <= WW'(MAX_WIDTH))
                 && (cfg_height >= HW'(3)) && (cfg_height <= HW'(MAX_HEIGHT));

   conv_window_3x3 #(
      .MAX_WIDTH  (MAX_WIDTH),
      .MAX_HEIGHT (MAX_HEIGHT),
      .PIX_W      (PIX_W)
   ) u_window (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .en        (en),
      .accept    (accept),
      .pix       (s_data),
      .width     (width_q),
      .height    (height_q),
      .win       (win),
      .win_valid (win_valid),
      .last      (last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: bad frame sizes skip straight to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = cfg_ok ? RUN : DONE;
         RUN:   if (last) state_nxt = DRAIN;
         DRAIN: if (!(win_valid || v2 || v3 || m_valid)) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Frame configuration and kernel, writable only while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         width_q  <= '0;
         height_q <= '0;
         relu_q   <= 1'b0;
         kern     <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            relu_q   <= relu_en;
         end
         if (coef_we) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  if (coef_addr == 4'(r*3+c)) kern[r][c] <= coef_data;
         end
      end
   end

   // Multiply stage: unsigned pixels become non-negative signed operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2 <= 1'b0;
         for (int i = 0; i < 9; i++) prod[i] <= '0;
      end else if (en) begin
         v2 <= win_valid;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               prod[r*3+c] <= PW'($signed({1'b0, win[r*3+c]}))
                            * PW'($signed(kern[r][c]));
      end
   end

   // Adder tree over the nine products.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < 9; i++) sum_c = sum_c + ACC_W'(prod[i]);
   end

   // Sum register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v3    <= 1'b0;
         sum_q <= '0;
      end else if (en) begin
         v3    <= v2;
         sum_q <= sum_c;
      end
   end

   // ReLU precedes saturation.
   always_comb begin
      act_c = sum_q;
      if (relu_q && sum_q < 0) act_c = '0;
   end

   // Output register; holds while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (en) begin
         m_valid <= v3;
         if (v3) m_data <= OUT_W'(sat_narrow(32'(act_c), OUT_W));
      end
   end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine.
// Directed frames push expected results; a monitor pops on each handshake.
module tb_conv2d_stream_engine;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [6:0]        cfg_width;
   logic [6:0]        cfg_height;
   logic              relu_en;
   logic              coef_we;
   logic [3:0]        coef_addr;
   logic signed [7:0] coef_data;
   logic              s_valid;
   logic              s_ready;
   logic [7:0]        s_data;
   logic              m_valid;
   logic              m_ready;
   logic signed [15:0] m_data;
   logic              busy;
   logic              done;

   int  exp_q [$];
   int  n_checks = 0;
   int  n_pass = 0;
   bit  chk_on = 1'b1;
   bit  bp = 1'b0;

   conv2d_stream_engine dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .relu_en    (relu_en),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   function automatic int pix(input int mode, input int x, input int y, input int w);
      case (mode)
         0: return y * w + x;
         1: return 10 * x;
         2: return 255;
         default: return x + y;
      endcase
   endfunction

   // Downstream ready: always or ~50% random.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compare each handshaken result and check stall stability.
   initial begin
      bit          stall_prev;
      logic [15:0] held;
      int          e;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (chk_on && !rst) begin
            if (stall_prev)
               chk(m_valid && m_data == held, "stall_hold", int'(m_data), int'(held));
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "extra_output", int'(m_data), 0);
               end else begin
                  e = exp_q.pop_front();
                  chk(int'(m_data) == e, "result", int'(m_data), e);
               end
            end
            stall_prev = m_valid && !m_ready;
            held = m_data;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   task automatic wr_coef(input int a, input int d);
      @(posedge clk); #1;
      coef_we = 1'b1;
      coef_addr = 4'(a);
      coef_data = 8'(d);
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic set_kernel(input int k [9]);
      for (int i = 0; i < 9; i++) wr_coef(i, k[i]);
   endtask

   task automatic start_frame(input int w, input int h, input bit relu);
      @(posedge clk); #1;
      cfg_width = 7'(w);
      cfg_height = 7'(h);
      relu_en = relu;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int w, input int mode, input bit rnd, input int limit);
      int n;
      int guard;
      bit acc;
      n = 0;
      guard = 0;
      while (n < limit && guard < 20000) begin
         s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data = 8'(pix(mode, n % w, n / w, w));
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk); #1;
         if (acc) n++;
         guard++;
      end
      s_valid = 1'b0;
      chk(n == limit, "feed_count", n, limit);
   endtask

   task automatic wait_done();
      int  cyc;
      bit  seen;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 3000) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         cyc++;
      end
      chk(seen, "done_pulse", int'(seen), 1);
      @(negedge clk);
      chk(!done && !busy, "done_one_cycle", int'(done), 0);
      chk(exp_q.size() == 0, "all_results_seen", exp_q.size(), 0);
   endtask

   task automatic push_identity8();
      for (int y = 2; y < 8; y++)
         for (int x = 2; x < 8; x++) exp_q.push_back((y - 1) * 8 + (x - 1));
   endtask

   task automatic run_frame(input int w, input int h, input bit relu,
                            input int mode, input bit rnd);
      start_frame(w, h, relu);
      chk(busy == 1'b1, "busy_in_run", int'(busy), 1);
      feed(w, mode, rnd, w * h);
      wait_done();
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      cfg_width = '0;
      cfg_height = '0;
      relu_en = 1'b0;
      coef_we = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      s_valid = 1'b0;
      s_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(!m_valid, "rst_m_valid", int'(m_valid), 0);
      chk(m_data == 0, "rst_m_data", int'(m_data), 0);
      chk(!s_ready, "rst_s_ready", int'(s_ready), 0);
      chk(!busy, "rst_busy", int'(busy), 0);
      chk(!done, "rst_done", int'(done), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Identity kernel, 8x8 ramp.
      set_kernel('{0, 0, 0, 0, 1, 0, 0, 0, 0});
      push_identity8();
      run_frame(8, 8, 1'b0, 0, 1'b0);

      // Sobel-x on a horizontal ramp, without and with ReLU.
      set_kernel('{1, 0, -1, 2, 0, -2, 1, 0, -1});
      for (int i = 0; i < 16; i++) exp_q.push_back(-80);
      run_frame(6, 6, 1'b0, 1, 1'b0);
      for (int i = 0; i < 16; i++) exp_q.push_back(0);
      run_frame(6, 6, 1'b1, 1, 1'b0);

      // Saturation at both rails.
      set_kernel('{127, 127, 127, 127, 127, 127, 127, 127, 127});
      for (int i = 0; i < 4; i++) exp_q.push_back(32767);
      run_frame(4, 4, 1'b0, 2, 1'b0);
      set_kernel('{-128, -128, -128, -128, -128, -128, -128, -128, -128});
      for (int i = 0; i < 4; i++) exp_q.push_back(-32768);
      run_frame(4, 4, 1'b0, 2, 1'b0);

      // Identity under random input bubbles and output backpressure.
      set_kernel('{0, 0, 0, 0, 1, 0, 0, 0, 0});
      bp = 1'b1;
      push_identity8();
      run_frame(8, 8, 1'b0, 0, 1'b1);
      bp = 1'b0;
      repeat (2) @(posedge clk);

      // Size edges: minimum frame, rejected width, full width.
      exp_q.push_back(4);
      run_frame(3, 3, 1'b0, 0, 1'b0);
      start_frame(2, 8, 1'b0);
      wait_done();
      for (int x = 2; x < 64; x++) exp_q.push_back(x);
      run_frame(64, 3, 1'b0, 3, 1'b0);

      // Reset in mid-frame discards everything, including the kernel.
      chk_on = 1'b0;
      start_frame(8, 8, 1'b0);
      feed(8, 0, 1'b0, 20);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk(!m_valid, "midrst_m_valid", int'(m_valid), 0);
      chk(m_data == 0, "midrst_m_data", int'(m_data), 0);
      chk(!busy, "midrst_busy", int'(busy), 0);
      chk(!done, "midrst_done", int'(done), 0);
      chk(!s_ready, "midrst_s_ready", int'(s_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_on = 1'b1;
      exp_q.push_back(0);
      run_frame(3, 3, 1'b0, 0, 1'b0);

      // Fresh identity frame; kernel writes during RUN are ignored.
      set_kernel('{0, 0, 0, 0, 1, 0, 0, 0, 0});
      push_identity8();
      start_frame(8, 8, 1'b0);
      chk(busy == 1'b1, "busy_in_run", int'(busy), 1);
      wr_coef(4, 5);
      wr_coef(0, 9);
      feed(8, 0, 1'b0, 64);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

endmodule
